// File: rtl/alu_exec_unit.sv
// Execute stage: ALU control decode, 32-bit ALU, PC adders, one output register stage.
// Optional build macro ALU_OVF_EN adds signed-overflow detection for ADD/SUB.
module alu_exec_unit #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        aluop,
  input  logic [5:0]        funct,
  input  logic [4:0]        shamt,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] imm_ext,
  input  logic              branch,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic [2:0]        gout,
  output logic [DATA_W-1:0] pc_plus4,
  output logic [DATA_W-1:0] next_pc,
  output logic              ovf,
  output logic              valid
);

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND = 3'b000;
  localparam logic [OP_W-1:0] OP_OR  = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD = 3'b010;
  localparam logic [OP_W-1:0] OP_SLL = 3'b011;
  localparam logic [OP_W-1:0] OP_SRL = 3'b100;
  localparam logic [OP_W-1:0] OP_NOR = 3'b101;
  localparam logic [OP_W-1:0] OP_SUB = 3'b110;
  localparam logic [OP_W-1:0] OP_SLT = 3'b111;

  logic [OP_W-1:0]   gout_c;
  logic [DATA_W-1:0] sum_c;
  logic [DATA_W-1:0] diff_c;
  logic [DATA_W-1:0] result_c;
  logic              zero_c;
  logic              ovf_c;
  logic [DATA_W-1:0] pc_plus4_c;
  logic [DATA_W-1:0] target_c;
  logic [DATA_W-1:0] next_pc_c;

  logic [DATA_W-1:0] result_q, pc_plus4_q, next_pc_q;
  logic [OP_W-1:0]   gout_q;
  logic              zero_q, ovf_q, valid_q;

  // ALU control decode
  always_comb begin
    gout_c = OP_ADD;
    unique case (aluop)
      2'b01:   gout_c = OP_SUB;
      2'b10: begin
        unique case (funct)
          6'b100000: gout_c = OP_ADD;
          6'b100010: gout_c = OP_SUB;
          6'b100100: gout_c = OP_AND;
          6'b100101: gout_c = OP_OR;
          6'b101010: gout_c = OP_SLT;
          6'b100111: gout_c = OP_NOR;
          6'b000000: gout_c = OP_SLL;
          6'b000010: gout_c = OP_SRL;
          default:   gout_c = OP_ADD;
        endcase
      end
      default: gout_c = OP_ADD;
    endcase
  end

  assign sum_c  = a + b;
  assign diff_c = a - b;

  always_comb begin
    result_c = sum_c;
    unique case (gout_c)
      OP_AND:  result_c = a & b;
      OP_OR:   result_c = a | b;
      OP_ADD:  result_c = sum_c;
      OP_SLL:  result_c = b << shamt;
      OP_SRL:  result_c = b >> shamt;
      OP_NOR:  result_c = ~(a | b);
      OP_SUB:  result_c = diff_c;
      OP_SLT:  result_c = DATA_W'($signed(a) < $signed(b));
      default: result_c = sum_c;
    endcase
  end

  assign zero_c = (result_c == '0);

`ifdef ALU_OVF_EN
  // Overflow only meaningful for ADD/SUB; the wrapped result is still delivered
  always_comb begin
    ovf_c = 1'b0;
    if (gout_c == OP_ADD)
      ovf_c = (a[DATA_W-1] == b[DATA_W-1]) && (sum_c[DATA_W-1] != a[DATA_W-1]);
    else if (gout_c == OP_SUB)
      ovf_c = (a[DATA_W-1] != b[DATA_W-1]) && (diff_c[DATA_W-1] != a[DATA_W-1]);
  end
`else
  assign ovf_c = 1'b0;
`endif

  assign pc_plus4_c = pc + DATA_W'(4);
  assign target_c   = pc_plus4_c + (imm_ext << 2);
  assign next_pc_c  = (branch && zero_c) ? target_c : pc_plus4_c;

  // Output register stage; data holds when en is low, valid tracks en
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q   <= '0;
      zero_q     <= 1'b0;
      gout_q     <= '0;
      pc_plus4_q <= '0;
      next_pc_q  <= '0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= en;
      if (en) begin
        result_q   <= result_c;
        zero_q     <= zero_c;
        gout_q     <= gout_c;
        pc_plus4_q <= pc_plus4_c;
        next_pc_q  <= next_pc_c;
        ovf_q      <= ovf_c;
      end
    end
  end

  assign result   = result_q;
  assign zero     = zero_q;
  assign gout     = gout_q;
  assign pc_plus4 = pc_plus4_q;
  assign next_pc  = next_pc_q;
  assign ovf      = ovf_q;
  assign valid    = valid_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit; honours ALU_OVF_EN for ovf expectations.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [1:0]  aluop;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] a, b, pc, imm_ext;
  logic        branch;
  logic [31:0] result, pc_plus4, next_pc;
  logic        zero, ovf, valid;
  logic [2:0]  gout;

  int total = 0;
  int bad   = 0;

`ifdef ALU_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  alu_exec_unit #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .aluop(aluop), .funct(funct),
    .shamt(shamt), .a(a), .b(b), .pc(pc), .imm_ext(imm_ext), .branch(branch),
    .result(result), .zero(zero), .gout(gout), .pc_plus4(pc_plus4),
    .next_pc(next_pc), .ovf(ovf), .valid(valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_res, input logic e_zero,
                         input logic [2:0] e_gout, input logic [31:0] e_p4,
                         input logic [31:0] e_npc, input logic e_ovf, input logic e_valid);
    chk({tag, ".result"},   result,          e_res);
    chk({tag, ".zero"},     32'(zero),       32'(e_zero));
    chk({tag, ".gout"},     32'(gout),       32'(e_gout));
    chk({tag, ".pc_plus4"}, pc_plus4,        e_p4);
    chk({tag, ".next_pc"},  next_pc,         e_npc);
    chk({tag, ".ovf"},      32'(ovf),        32'(e_ovf));
    chk({tag, ".valid"},    32'(valid),      32'(e_valid));
  endtask

  // Inputs were set mid-cycle; advance past the next edge and sample away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                        input logic [31:0] va, input logic [31:0] vb);
    aluop = op; funct = fn; shamt = sh; a = va; b = vb;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; branch = 1'b0;
    pc = 32'h0; imm_ext = 32'h0;
    set_op(2'b00, 6'h0, 5'd0, 32'h0, 32'h0);
    #3;
    chk_all("reset", 32'h0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    pc = 32'h100;

    set_op(2'b10, 6'b100000, 5'd0, 32'd5, 32'd7);
    tick();
    chk_all("add", 32'd12, 1'b0, 3'b010, 32'h104, 32'h104, 1'b0, 1'b1);

    set_op(2'b10, 6'b100010, 5'd0, 32'd5, 32'd7);
    tick();
    chk_all("sub", 32'hFFFF_FFFE, 1'b0, 3'b110, 32'h104, 32'h104, 1'b0, 1'b1);

    set_op(2'b10, 6'b100100, 5'd0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    tick();
    chk_all("and", 32'h00F0_00F0, 1'b0, 3'b000, 32'h104, 32'h104, 1'b0, 1'b1);

    set_op(2'b10, 6'b100101, 5'd0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    tick();
    chk_all("or", 32'hFFF0_FFF0, 1'b0, 3'b001, 32'h104, 32'h104, 1'b0, 1'b1);

    set_op(2'b10, 6'b100111, 5'd0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    tick();
    chk_all("nor", 32'h000F_000F, 1'b0, 3'b101, 32'h104, 32'h104, 1'b0, 1'b1);

    set_op(2'b10, 6'b101010, 5'd0, 32'hFFFF_FFFF, 32'd1);
    tick();
    chk_all("slt_neg", 32'd1, 1'b0, 3'b111, 32'h104, 32'h104, 1'b0, 1'b1);

    set_op(2'b10, 6'b101010, 5'd0, 32'd1, 32'hFFFF_FFFF);
    tick();
    chk_all("slt_pos", 32'd0, 1'b1, 3'b111, 32'h104, 32'h104, 1'b0, 1'b1);

    set_op(2'b10, 6'b000000, 5'd31, 32'h1234_5678, 32'd1);
    tick();
    chk_all("sll", 32'h8000_0000, 1'b0, 3'b011, 32'h104, 32'h104, 1'b0, 1'b1);

    set_op(2'b10, 6'b000010, 5'd4, 32'h0, 32'h8000_0000);
    tick();
    chk_all("srl", 32'h0800_0000, 1'b0, 3'b100, 32'h104, 32'h104, 1'b0, 1'b1);

    set_op(2'b10, 6'b000010, 5'd0, 32'h0, 32'hDEAD_BEEF);
    tick();
    chk_all("srl0", 32'hDEAD_BEEF, 1'b0, 3'b100, 32'h104, 32'h104, 1'b0, 1'b1);

    set_op(2'b10, 6'b111111, 5'd0, 32'd3, 32'd4);
    tick();
    chk_all("funct_dflt", 32'd7, 1'b0, 3'b010, 32'h104, 32'h104, 1'b0, 1'b1);

    set_op(2'b00, 6'b100010, 5'd0, 32'd10, 32'd20);
    tick();
    chk_all("aluop00", 32'd30, 1'b0, 3'b010, 32'h104, 32'h104, 1'b0, 1'b1);

    set_op(2'b11, 6'b100010, 5'd0, 32'd1, 32'd2);
    tick();
    chk_all("aluop11", 32'd3, 1'b0, 3'b010, 32'h104, 32'h104, 1'b0, 1'b1);

    // Branch taken: target = 0x14 + (-2 << 2) = 0x0C
    pc = 32'h10; imm_ext = 32'hFFFF_FFFE; branch = 1'b1;
    set_op(2'b01, 6'h0, 5'd0, 32'd9, 32'd9);
    tick();
    chk_all("br_taken", 32'd0, 1'b1, 3'b110, 32'h14, 32'h0C, 1'b0, 1'b1);

    set_op(2'b01, 6'h0, 5'd0, 32'd9, 32'd8);
    tick();
    chk_all("br_not", 32'd1, 1'b0, 3'b110, 32'h14, 32'h14, 1'b0, 1'b1);

    branch = 1'b0;
    set_op(2'b01, 6'h0, 5'd0, 32'd9, 32'd9);
    tick();
    chk_all("nobr_zero", 32'd0, 1'b1, 3'b110, 32'h14, 32'h14, 1'b0, 1'b1);

    // Hold: en low keeps data, valid drops
    en = 1'b0; branch = 1'b1; pc = 32'h400; imm_ext = 32'h10;
    set_op(2'b10, 6'b100101, 5'd3, 32'hAAAA_AAAA, 32'h5555_5555);
    tick();
    chk_all("hold1", 32'd0, 1'b1, 3'b110, 32'h14, 32'h14, 1'b0, 1'b0);
    tick();
    chk_all("hold2", 32'd0, 1'b1, 3'b110, 32'h14, 32'h14, 1'b0, 1'b0);

    en = 1'b1; branch = 1'b0; pc = 32'hFFFF_FFFC; imm_ext = 32'h0;
    set_op(2'b10, 6'b100000, 5'd0, 32'h7FFF_FFFF, 32'd1);
    tick();
    chk_all("add_ovf", 32'h8000_0000, 1'b0, 3'b010, 32'h0, 32'h0, OVF_ON, 1'b1);

    pc = 32'h200;
    set_op(2'b10, 6'b100010, 5'd0, 32'h8000_0000, 32'd1);
    tick();
    chk_all("sub_ovf", 32'h7FFF_FFFF, 1'b0, 3'b110, 32'h204, 32'h204, OVF_ON, 1'b1);

    set_op(2'b10, 6'b100100, 5'd0, 32'h7FFF_FFFF, 32'd1);
    tick();
    chk_all("and_noovf", 32'd1, 1'b0, 3'b000, 32'h204, 32'h204, 1'b0, 1'b1);

    // Asynchronous reset mid-cycle, away from any clock edge
    set_op(2'b10, 6'b100101, 5'd0, 32'h1, 32'h2);
    tick();
    chk("pre_rst.result", result, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 32'h0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
